// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and types for the fixed-point multiply-accumulate unit
package mac_pkg;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int ACC_W  = 40;

   typedef logic signed [DATA_W-1:0]   operand_t;
   typedef logic signed [2*DATA_W-1:0] product_t;
   typedef logic signed [ACC_W-1:0]    acc_t;
endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed Q-format multiply-accumulate with clear/restart and wrapping accumulator
module mac_unit #(
   parameter int DATA_W = mac_pkg::DATA_W,
   parameter int FRAC_W = mac_pkg::FRAC_W,
   parameter int ACC_W  = mac_pkg::ACC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] din_x,
   input  logic signed [DATA_W-1:0] din_w,
   input  logic                     valid_in,
   input  logic                     clr_acc,
   output logic signed [ACC_W-1:0]  dout
);
   localparam int PROD_W = 2 * DATA_W;

   generate
      if (ACC_W < PROD_W - FRAC_W || FRAC_W >= PROD_W) begin : g_bad_params
         $error("mac_unit: ACC_W too narrow for rescaled product or FRAC_W >= 2*DATA_W");
      end
   endgenerate

   logic signed [PROD_W-1:0] product;
   logic signed [PROD_W-1:0] shifted;
   logic signed [ACC_W-1:0]  scaled;
   logic signed [ACC_W-1:0]  acc;

   // Arithmetic shift floors toward minus infinity; no rounding term is added.
   always_comb begin
      product = PROD_W'(din_x) * PROD_W'(din_w);
      shifted = product >>> FRAC_W;
      scaled  = ACC_W'(shifted);
   end

   // An unknown clr_acc falls through to the accumulate/hold branches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr_acc)
         acc <= valid_in ? scaled : '0;
      else if (valid_in)
         acc <= acc + scaled;
   end

   assign dout = acc;
endmodule

// File: tb/tb_mac_unit.sv
// tb/tb_mac_unit.sv - self-checking bench for mac_unit
module tb_mac_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic signed [15:0] x, w;
   logic v, c;
   logic signed [39:0] dout;
   logic signed [23:0] x2, w2;
   logic v2, c2;
   logic signed [39:0] dout2;

   longint m_acc = 0;
   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   localparam longint MASK40 = 64'h0000_00FF_FFFF_FFFF;

   mac_unit dut (
      .clk(clk), .rst_n(rst_n), .din_x(x), .din_w(w),
      .valid_in(v), .clr_acc(c), .dout(dout)
   );

   mac_unit #(.DATA_W(24), .FRAC_W(8), .ACC_W(40)) dut_wide (
      .clk(clk), .rst_n(rst_n), .din_x(x2), .din_w(w2),
      .valid_in(v2), .clr_acc(c2), .dout(dout2)
   );

   always #5 clk = ~clk;

   // Exact product divided by 2^8, rounded toward minus infinity.
   function automatic longint scaled_product(input logic signed [15:0] a, input logic signed [15:0] b);
      longint p;
      longint q;
      p = longint'(a) * longint'(b);
      q = p / 256;
      if (p < 0 && (q * 256) != p) q = q - 1;
      return q;
   endfunction

   // Dot-product semantics: a clear restarts the sum, a valid pair contributes, result mod 2^40.
   task automatic model_step();
      longint base;
      longint term;
      if (!rst_n) begin
         m_acc = 0;
      end else begin
         base  = c ? 0 : m_acc;
         term  = v ? scaled_product(x, w) : 0;
         m_acc = (base + term) & MASK40;
      end
   endtask

   task automatic drive(input logic [15:0] xi, input logic [15:0] wi, input logic vi, input logic ci);
      x = xi; w = wi; v = vi; c = ci;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive_wide(input logic [23:0] xi, input logic [23:0] wi);
      x2 = xi; w2 = wi; v2 = 1'b1;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (dout !== 40'(m_acc)) begin
            errors++;
            $display("FAIL model_cmp at %0t: got %h expected %h", $time, dout, 40'(m_acc));
         end
      end
   end

   initial begin
      x = '0; w = '0; v = 1'b0; c = 1'b0;
      x2 = '0; w2 = '0; v2 = 1'b0; c2 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_dout", dout, 40'h0);
      chk("reset_dout_wide", dout2, 40'h0);
      cmp_en = 1'b1;

      v = 1'b1; c = 1'b1; x = 16'h0100; w = 16'h0100;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ignores_inputs", dout, 40'h0);
      rst_n = 1'b1;

      drive(16'h0080, 16'h0200, 1'b1, 1'b0); chk("acc_step1", dout, 40'h0000000100);
      drive(16'h0100, 16'h0100, 1'b1, 1'b0); chk("acc_step2", dout, 40'h0000000200);
      drive(16'h0080, 16'hFF00, 1'b1, 1'b0); chk("acc_step3", dout, 40'h0000000180);
      drive(16'hFE00, 16'hFF80, 1'b1, 1'b0); chk("acc_step4", dout, 40'h0000000280);

      repeat (5) begin
         drive(16'($urandom), 16'($urandom), 1'b0, 1'b0);
         chk("hold", dout, 40'h0000000280);
      end

      drive(16'h1234, 16'h5678, 1'b0, 1'b1); chk("clear_to_zero", dout, 40'h0);
      drive(16'h0001, 16'h0001, 1'b1, 1'b0); chk("floor_pos", dout, 40'h0);
      drive(16'hFFFF, 16'h0001, 1'b1, 1'b0); chk("floor_neg", dout, 40'hFFFFFFFFFF);
      drive(16'h0F0F, 16'h7777, 1'b0, 1'b1); chk("clear_idle", dout, 40'h0);
      drive(16'h0100, 16'h0300, 1'b1, 1'b1); chk("clear_restart", dout, 40'h0000000300);

      drive(16'h8000, 16'h8000, 1'b1, 1'b0);
      drive(16'h8000, 16'h7FFF, 1'b1, 1'b0);
      drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      repeat (30) begin
         drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 7) == 0));
      end

      drive(16'h0100, 16'h0300, 1'b1, 1'b1); chk("restart_before_reset", dout, 40'h0000000300);
      #2 rst_n = 1'b0;
      m_acc = 0;
      #1 chk("async_reset_immediate", dout, 40'h0);
      drive(16'h0100, 16'h0100, 1'b1, 1'b1); chk("reset_hold1", dout, 40'h0);
      drive(16'h0100, 16'h0100, 1'b1, 1'b0); chk("reset_hold2", dout, 40'h0);
      rst_n = 1'b1;
      drive(16'h0100, 16'h0100, 1'b1, 1'b0); chk("first_after_reset", dout, 40'h0000000100);

      v = 1'b0;
      repeat (7) drive_wide(24'h400000, 24'h400000);
      chk("wide_preload_partial", dout2, 40'h7000000000);
      drive_wide(24'h7F0000, 24'h204081);
      chk("wide_preload", dout2, 40'h7FFFFFFF00);
      drive_wide(24'h000100, 24'h000100);
      chk("wraparound", dout2, 40'h8000000000);
      v2 = 1'b0;

      @(negedge clk);
      #1 cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
